// File: rtl/uart_fifo_sched.sv
// Scheduler between the UART RX FIFO, a local byte source, the TX FIFO and the UART transmitter.
// Round-robin push arbitration into the TX FIFO plus a drain FSM that feeds one byte per frame.
module uart_fifo_sched #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned BUSY_TO = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_empty,
    input  logic [DATA_W-1:0] i_rx_data,
    output logic              o_rx_pop,
    input  logic              i_loc_req,
    input  logic [DATA_W-1:0] i_loc_data,
    output logic              o_loc_ack,
    input  logic              i_tx_full,
    output logic              o_tx_push,
    output logic [DATA_W-1:0] o_tx_push_data,
    input  logic              i_txf_empty,
    input  logic [DATA_W-1:0] i_txf_data,
    output logic              o_txf_pop,
    input  logic              i_uart_busy,
    output logic              o_uart_start,
    output logic [DATA_W-1:0] o_uart_data,
    output logic [CNT_W-1:0]  o_tx_count,
    output logic              o_err_to
);

    localparam int unsigned TO_W = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last_loc;
    logic [TO_W-1:0]   r_to_cnt;
    logic [DATA_W-1:0] r_uart_data;
    logic [CNT_W-1:0]  r_tx_count;
    logic              r_err_to;
    logic              w_grant_rx;
    logic              w_grant_loc;
    logic              w_to_hit;
    logic              w_frame_done;

    // Push arbiter: on a tie the requester not served last wins; held off entirely by tx_full.
    always_comb begin
        w_grant_rx     = !i_rst && !i_tx_full && !i_rx_empty && (!i_loc_req || r_last_loc);
        w_grant_loc    = !i_rst && !i_tx_full && i_loc_req && (i_rx_empty || !r_last_loc);
        o_rx_pop       = w_grant_rx;
        o_loc_ack      = w_grant_loc;
        o_tx_push      = w_grant_rx || w_grant_loc;
        o_tx_push_data = '0;
        if (w_grant_rx) begin
            o_tx_push_data = i_rx_data;
        end else if (w_grant_loc) begin
            o_tx_push_data = i_loc_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_loc <= 1'b1;
        end else if (w_grant_rx) begin
            r_last_loc <= 1'b0;
        end else if (w_grant_loc) begin
            r_last_loc <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (!i_txf_empty && !i_uart_busy) w_next = S_START;
            S_START:     w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (i_uart_busy) begin
                    w_next = S_WAIT_DONE;
                end else if (r_to_cnt == TO_W'(BUSY_TO - 1)) begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT_DONE: if (!i_uart_busy) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_txf_pop    = 1'b0;
        o_uart_start = 1'b0;
        w_to_hit     = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE:      o_txf_pop    = !i_rst && !i_txf_empty && !i_uart_busy;
            S_START:     o_uart_start = 1'b1;
            S_WAIT_BUSY: w_to_hit     = !i_uart_busy && (r_to_cnt == TO_W'(BUSY_TO - 1));
            S_WAIT_DONE: w_frame_done = !i_uart_busy;
            default:     ;
        endcase
    end

    // Frame datapath: latched byte, busy-timeout counter, frame counter and sticky error.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_uart_data <= '0;
            r_to_cnt    <= '0;
            r_tx_count  <= '0;
            r_err_to    <= 1'b0;
        end else begin
            if (o_txf_pop) begin
                r_uart_data <= i_txf_data;
            end
            if (r_state == S_START) begin
                r_to_cnt <= '0;
            end else if (r_state == S_WAIT_BUSY && !i_uart_busy && !w_to_hit) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            if (w_to_hit) begin
                r_err_to <= 1'b1;
            end
            if (w_frame_done) begin
                r_tx_count <= r_tx_count + CNT_W'(1);
            end
        end
    end

    assign o_uart_data = r_uart_data;
    assign o_tx_count  = r_tx_count;
    assign o_err_to    = r_err_to;

endmodule

// File: tb/tb_uart_fifo_sched.sv
// Self-checking bench for uart_fifo_sched: directed arbiter/drain scenarios plus a randomized
// arbitration run against a round-robin model, with a modelled TX FIFO and transmitter.
module tb_uart_fifo_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_empty, loc_req, tx_full, txf_empty, uart_busy;
    logic [7:0] rx_data, loc_data, txf_data;
    logic       rx_pop, loc_ack, tx_push, txf_pop, uart_start, err_to;
    logic [7:0] tx_push_data, uart_data;
    logic [15:0] tx_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] txq[$];
    logic [7:0] add_q[$];
    logic [7:0] exp_q[$];
    bit         xmt_dead = 1'b0;
    bit         m_last_loc;

    always #5 clk = ~clk;

    uart_fifo_sched dut (
        .i_clk(clk), .i_rst(rst),
        .i_rx_empty(rx_empty), .i_rx_data(rx_data), .o_rx_pop(rx_pop),
        .i_loc_req(loc_req), .i_loc_data(loc_data), .o_loc_ack(loc_ack),
        .i_tx_full(tx_full), .o_tx_push(tx_push), .o_tx_push_data(tx_push_data),
        .i_txf_empty(txf_empty), .i_txf_data(txf_data), .o_txf_pop(txf_pop),
        .i_uart_busy(uart_busy), .o_uart_start(uart_start), .o_uart_data(uart_data),
        .o_tx_count(tx_count), .o_err_to(err_to)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic add_tx(input logic [7:0] b);
        add_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        m_last_loc = 1'b1;
    endtask

    // TX FIFO model: first-word-fall-through, pop takes effect at the clock edge.
    initial begin
        bit p;
        txf_empty = 1'b1;
        txf_data  = 8'h00;
        forever begin
            @(negedge clk);
            p = txf_pop;
            if (p) check("pop_nonempty", 32'(txq.size() != 0), 32'd1);
            @(posedge clk);
            #1;
            if (p && txq.size() > 0) void'(txq.pop_front());
            while (add_q.size() > 0) txq.push_back(add_q.pop_front());
            txf_empty = (txq.size() == 0);
            txf_data  = (txq.size() == 0) ? 8'h00 : txq[0];
        end
    end

    // Transmitter model: busy one cycle after start, ten cycles long; can be made unresponsive.
    initial begin
        bit prev_start = 1'b0;
        uart_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_start) begin
                check("start_pulse", 32'(prev_start), 32'd0);
                if (exp_q.size() == 0) begin
                    check("start_unexpected", 32'd1, 32'd0);
                end else begin
                    check("uart_data", 32'(uart_data), 32'(exp_q.pop_front()));
                end
                if (!xmt_dead) begin
                    @(posedge clk);
                    #1 uart_busy = 1'b1;
                    repeat (10) @(posedge clk);
                    #1 uart_busy = 1'b0;
                end
            end
            prev_start = uart_start;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit er, el, ef, g_rx, g_loc;
        logic [7:0] dr, dl, exp_d;

        rst = 1'b1; rx_empty = 1'b0; rx_data = 8'h99; loc_req = 1'b1; loc_data = 8'h77;
        tx_full = 1'b0;
        #2;
        check("rst_rx_pop", 32'(rx_pop), 32'd0);
        check("rst_loc_ack", 32'(loc_ack), 32'd0);
        check("rst_tx_push", 32'(tx_push), 32'd0);
        check("rst_push_data", 32'(tx_push_data), 32'd0);
        check("rst_start", 32'(uart_start), 32'd0);
        check("rst_uart_data", 32'(uart_data), 32'd0);
        check("rst_count", 32'(tx_count), 32'd0);
        check("rst_err", 32'(err_to), 32'd0);
        rx_empty = 1'b1; loc_req = 1'b0;
        step();
        do_reset();

        // Single RX byte.
        rx_empty = 1'b0; rx_data = 8'h41;
        #1;
        check("t1_rx_pop", 32'(rx_pop), 32'd1);
        check("t1_push", 32'(tx_push), 32'd1);
        check("t1_data", 32'(tx_push_data), 32'h41);
        check("t1_loc_ack", 32'(loc_ack), 32'd0);
        step();
        rx_empty = 1'b1;
        #1;
        check("t1_idle_push", 32'(tx_push), 32'd0);

        // Alternation with both pending.
        do_reset();
        rx_empty = 1'b0; rx_data = 8'h10; loc_req = 1'b1; loc_data = 8'h20;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_data", 32'(tx_push_data), (i % 2 == 1) ? 32'h20 : 32'h10);
            check("t2_loc_ack", 32'(loc_ack), 32'(i % 2));
            check("t2_rx_pop", 32'(rx_pop), 32'(1 - i % 2));
            step();
        end

        // Backpressure, then RX wins first after LOC was last.
        tx_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_push", 32'(tx_push), 32'd0);
            check("t3_pops", 32'({rx_pop, loc_ack}), 32'd0);
            step();
        end
        tx_full = 1'b0;
        #1;
        check("t3_rx_first", 32'(rx_pop), 32'd1);
        check("t3_data", 32'(tx_push_data), 32'h10);
        step();
        rx_empty = 1'b1; loc_req = 1'b0;

        // Randomized arbitration against a round-robin model.
        do_reset();
        for (int i = 0; i < 150; i++) begin
            er = 1'($urandom_range(0, 1));
            el = 1'($urandom_range(0, 1));
            ef = ($urandom_range(0, 3) == 0);
            dr = 8'($urandom);
            dl = 8'($urandom);
            rx_empty = !er; rx_data = dr; loc_req = el; loc_data = dl; tx_full = ef;
            g_rx = 1'b0; g_loc = 1'b0;
            if (!ef) begin
                if (er && el) begin
                    if (m_last_loc) g_rx = 1'b1; else g_loc = 1'b1;
                end else begin
                    g_rx = er;
                    g_loc = el;
                end
            end
            if (g_rx) m_last_loc = 1'b0;
            if (g_loc) m_last_loc = 1'b1;
            exp_d = g_rx ? dr : (g_loc ? dl : 8'h00);
            #1;
            check("rnd_rx_pop", 32'(rx_pop), 32'(g_rx));
            check("rnd_loc_ack", 32'(loc_ack), 32'(g_loc));
            check("rnd_push", 32'(tx_push), 32'(g_rx | g_loc));
            check("rnd_data", 32'(tx_push_data), 32'(exp_d));
            step();
        end
        rx_empty = 1'b1; loc_req = 1'b0; tx_full = 1'b0;

        // Normal frame.
        do_reset();
        add_tx(8'h55);
        for (int i = 0; i < 10 && !txf_pop; i++) step();
        check("t4_pop", 32'(txf_pop), 32'd1);
        step();
        check("t4_start", 32'(uart_start), 32'd1);
        check("t4_uart_data", 32'(uart_data), 32'h55);
        check("t4_no_pop", 32'(txf_pop), 32'd0);
        step();
        check("t4_start_low", 32'(uart_start), 32'd0);
        check("t4_count_busy", 32'(tx_count), 32'd0);
        for (int i = 0; i < 30 && tx_count != 16'd1; i++) step();
        check("t4_count", 32'(tx_count), 32'd1);

        // Busy never rises: timeout after START plus 16 cycles.
        xmt_dead = 1'b1;
        add_tx(8'hA5);
        for (int i = 0; i < 10 && !uart_start; i++) step();
        check("t5_start", 32'(uart_start), 32'd1);
        repeat (16) step();
        check("t5_err_early", 32'(err_to), 32'd0);
        step();
        check("t5_err", 32'(err_to), 32'd1);
        check("t5_count", 32'(tx_count), 32'd1);
        check("t5_idle", 32'(uart_start), 32'd0);
        xmt_dead = 1'b0;
        add_tx(8'h3C);
        for (int i = 0; i < 40 && tx_count != 16'd2; i++) step();
        check("t5_next", 32'(tx_count), 32'd2);
        check("t5_err_sticky", 32'(err_to), 32'd1);

        // Reset in the middle of a frame.
        add_tx(8'h11);
        for (int i = 0; i < 40 && tx_count != 16'd3; i++) step();
        check("t6_count3", 32'(tx_count), 32'd3);
        add_tx(8'hC3);
        for (int i = 0; i < 10 && !uart_start; i++) step();
        check("t6_start", 32'(uart_start), 32'd1);
        repeat (3) step();
        check("t6_busy", 32'(uart_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_count", 32'(tx_count), 32'd0);
        check("t6_rst_start", 32'(uart_start), 32'd0);
        check("t6_rst_err", 32'(err_to), 32'd0);
        check("t6_rst_data", 32'(uart_data), 32'd0);
        step();
        rst = 1'b0;
        add_tx(8'h7E);
        for (int i = 0; i < 60 && tx_count != 16'd1; i++) step();
        check("t6_after", 32'(tx_count), 32'd1);
        check("t6_err_after", 32'(err_to), 32'd0);
        repeat (5) step();
        check("all_sent", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
